// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that grants one of four requesters and routes its
// word through a shared 4:1 mux, with a bounded tenure under contention.
module rr_mux_arbiter #(
    parameter int DW       = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] A,
    output logic [3:0]      gnt,
    output logic [1:0]      sel,
    output logic [DW-1:0]   out,
    output logic            out_vld
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam logic [3:0] LP_MAX = 4'(MAX_HOLD);

    state_t      r_state;
    state_t      w_nxt_state;
    logic [3:0]  r_gnt;
    logic [3:0]  w_nxt_gnt;
    logic [1:0]  r_sel;
    logic [1:0]  w_nxt_sel;
    logic [1:0]  r_ptr;
    logic [1:0]  w_nxt_ptr;
    logic [3:0]  r_hold;
    logic [3:0]  w_nxt_hold;

    logic [3:0]  w_others;
    logic        w_release;
    logic [3:0]  w_cand;
    logic [1:0]  w_start;
    logic [1:0]  w_idx;
    logic        w_found;
    logic [1:0]  w_win;
    logic [DW-1:0] w_slice [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_gnt   <= w_nxt_gnt;
            r_sel   <= w_nxt_sel;
            r_ptr   <= w_nxt_ptr;
            r_hold  <= w_nxt_hold;
        end
    end

    // In BUSY the owner is excluded, so a re-raised owner waits its turn.
    always_comb begin
        w_others  = req & ~r_gnt;
        w_release = !req[r_sel] || ((r_hold == LP_MAX) && (|w_others));
        w_cand    = (r_state == IDLE) ? req : w_others;
        w_start   = (r_state == IDLE) ? r_ptr : r_sel + 2'd1;
        w_found   = 1'b0;
        w_win     = '0;
        w_idx     = '0;
        for (int k = 3; k >= 0; k--) begin
            w_idx = w_start + 2'(k);
            if (w_cand[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_gnt   = r_gnt;
        w_nxt_sel   = r_sel;
        w_nxt_ptr   = r_ptr;
        w_nxt_hold  = r_hold;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_nxt_state = BUSY;
                    w_nxt_gnt   = 4'b0001 << w_win;
                    w_nxt_sel   = w_win;
                    w_nxt_hold  = 4'd1;
                end
            end
            BUSY: begin
                if (w_release) begin
                    w_nxt_ptr = r_sel + 2'd1;
                    if (w_found) begin
                        w_nxt_gnt  = 4'b0001 << w_win;
                        w_nxt_sel  = w_win;
                        w_nxt_hold = 4'd1;
                    end else begin
                        w_nxt_state = IDLE;
                        w_nxt_gnt   = '0;
                        w_nxt_hold  = '0;
                    end
                end else if (r_hold != LP_MAX) begin
                    w_nxt_hold = r_hold + 4'd1;
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    for (genvar g = 0; g < 4; g++) begin : g_slice
        assign w_slice[g] = A[g*DW +: DW];
    end

    assign gnt     = r_gnt;
    assign sel     = r_sel;
    assign out_vld = |r_gnt;
    assign out     = out_vld ? w_slice[r_sel] : '0;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: expected grant/select/data pushed
// per driven cycle, popped and compared one step after the clock edge.
module tb_rr_mux_arbiter;

    localparam int DW = 8;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic [7:0] out;
        logic       vld;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [3:0]    req;
    logic [4*DW-1:0] A;
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic [DW-1:0] out;
    logic          out_vld;

    exp_t q[$];
    exp_t e;
    int   n_vec;
    int   n_err;

    rr_mux_arbiter #(.DW(DW), .MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .A(A),
        .gnt(gnt), .sel(sel), .out(out), .out_vld(out_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [3:0] g, input logic [1:0] s);
        exp_t r;
        r.gnt = g;
        r.sel = s;
        r.out = 8'h00;
        r.vld = |g;
        for (int i = 0; i < 4; i++)
            if (g[i]) begin
                r.sel = 2'(i);
                r.out = 8'hA0 + 8'(8'h11 * i);
            end
        return r;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        q.push_back(mk(4'b0000, 2'd0));
        repeat (2) @(posedge clk);
        #1;
        e = q.pop_front();
        n_vec++;
        if ({gnt, sel, out, out_vld} !== {e.gnt, e.sel, e.out, e.vld}) begin
            n_err++;
            $display("FAIL reset: gnt=%b sel=%0d out=%h vld=%b want %b %0d %h %b",
                     gnt, sel, out, out_vld, e.gnt, e.sel, e.out, e.vld);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [3:0] st [2];
        logic [3:0] ex [2];
        logic [1:0] ls;
        st = '{4'b0100, 4'b0000};
        ex = '{4'b0100, 4'b0000};
        ls = 2'd0;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            req = st[k];
            q.push_back(mk(ex[k], ls));
            ls = q[$].sel;
            @(posedge clk);
            #1;
            e = q.pop_front();
            n_vec++;
            if ({gnt, sel, out, out_vld} !== {e.gnt, e.sel, e.out, e.vld}) begin
                n_err++;
                $display("FAIL single c%0d: gnt=%b sel=%0d out=%h vld=%b want %b %0d %h %b",
                         k, gnt, sel, out, out_vld, e.gnt, e.sel, e.out, e.vld);
            end
        end
    endtask

    task automatic test_rotation();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            req = 4'b1111;
            q.push_back(mk(4'b0001 << ((k / 4) % 4), 2'd0));
            @(posedge clk);
            #1;
            e = q.pop_front();
            n_vec++;
            if ({gnt, sel, out, out_vld} !== {e.gnt, e.sel, e.out, e.vld}) begin
                n_err++;
                $display("FAIL rotation c%0d: gnt=%b sel=%0d out=%h vld=%b want %b %0d %h %b",
                         k, gnt, sel, out, out_vld, e.gnt, e.sel, e.out, e.vld);
            end
        end
    endtask

    task automatic test_alone();
        logic [3:0] r;
        logic [3:0] x;
        do_reset();
        for (int k = 0; k < 26; k++) begin
            r = (k < 20) ? 4'b0010 : 4'b1010;
            x = (k < 20) ? 4'b0010 : (k < 24) ? 4'b1000 : 4'b0010;
            req = r;
            q.push_back(mk(x, 2'd0));
            @(posedge clk);
            #1;
            e = q.pop_front();
            n_vec++;
            if ({gnt, sel, out, out_vld} !== {e.gnt, e.sel, e.out, e.vld}) begin
                n_err++;
                $display("FAIL alone c%0d: gnt=%b sel=%0d out=%h vld=%b want %b %0d %h %b",
                         k, gnt, sel, out, out_vld, e.gnt, e.sel, e.out, e.vld);
            end
        end
    endtask

    task automatic test_drop();
        logic [3:0] st [7];
        logic [3:0] ex [7];
        st = '{4'b0101, 4'b0101, 4'b0100, 4'b0101, 4'b0101, 4'b0101, 4'b0101};
        ex = '{4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
        do_reset();
        for (int k = 0; k < 7; k++) begin
            req = st[k];
            q.push_back(mk(ex[k], 2'd0));
            @(posedge clk);
            #1;
            e = q.pop_front();
            n_vec++;
            if ({gnt, sel, out, out_vld} !== {e.gnt, e.sel, e.out, e.vld}) begin
                n_err++;
                $display("FAIL drop c%0d: gnt=%b sel=%0d out=%h vld=%b want %b %0d %h %b",
                         k, gnt, sel, out, out_vld, e.gnt, e.sel, e.out, e.vld);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b1000;
        q.push_back(mk(4'b1000, 2'd0));
        q.push_back(mk(4'b0000, 2'd0));
        q.push_back(mk(4'b0001, 2'd0));
        for (int k = 0; k < 3; k++) begin
            if (k == 0) begin
                @(posedge clk);
                #1;
            end else if (k == 1) begin
                #2;
                rst_n = 1'b0;
                #1;
            end else begin
                req = 4'b1111;
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk);
                #1;
            end
            e = q.pop_front();
            n_vec++;
            if ({gnt, sel, out, out_vld} !== {e.gnt, e.sel, e.out, e.vld}) begin
                n_err++;
                $display("FAIL reset_mid s%0d: gnt=%b sel=%0d out=%h vld=%b want %b %0d %h %b",
                         k, gnt, sel, out, out_vld, e.gnt, e.sel, e.out, e.vld);
            end
        end
    endtask

    task automatic test_fairness();
        logic [3:0] x;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            req = (k < 4) ? 4'b0010 : 4'b0011;
            x = (k < 4) ? 4'b0010 : (k < 8) ? 4'b0001 : 4'b0010;
            q.push_back(mk(x, 2'd0));
            @(posedge clk);
            #1;
            e = q.pop_front();
            n_vec++;
            if ({gnt, sel, out, out_vld} !== {e.gnt, e.sel, e.out, e.vld}) begin
                n_err++;
                $display("FAIL fairness c%0d: gnt=%b sel=%0d out=%h vld=%b want %b %0d %h %b",
                         k, gnt, sel, out, out_vld, e.gnt, e.sel, e.out, e.vld);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        req   = 4'b0000;
        A     = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        test_reset();
        test_single();
        test_rotation();
        test_alone();
        test_drop();
        test_reset_mid();
        test_fairness();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 data mux among four requesters.
- Each requester raises a request line. The block grants one requester at a time, drives the mux select, and routes the winner's DW-bit word to the shared output.
- Grant tenure is bounded by MAX_HOLD cycles when another requester is waiting.
- Sits in front of any single-consumer resource fed by four sources.

Parameters:
DW, 8, data width per requester.
MAX_HOLD, 4, maximum consecutive grant cycles while another requester waits; legal range 1..15.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
req  input  4  request lines; req[i] held high while requester i wants the resource.
A  input  4*DW  requester data; slice i is A[i*DW +: DW].
gnt  output  4  registered one-hot grant; all zero when idle.
sel  output  2  registered mux select; equals the index of the set gnt bit. Holds its last value when idle.
out  output  DW  mux output: A slice indexed by sel when any gnt bit is set, else 0 (combinational from sel/gnt/A).
out_vld  output  1  equals |gnt.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; gnt=0; sel=0; out_vld=0; out=0.
  - Pointer ptr=0; hold_cnt=0.
  - Reset asserted mid-grant clears gnt immediately, without waiting for a clock edge.
  - The first grant after reset searches from index 0.
- State IDLE:
  - On a clock edge with req!=0, grant the first set bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Set gnt and sel, hold_cnt=1, go to BUSY.
  - Latency: req high at edge N gives gnt at edge N, visible through cycle N+1. The earliest grant is one clock after req is driven.
  - If req==0, stay in IDLE.
- State BUSY, owner o = sel:
  - Release when req[o]==0, OR when hold_cnt==MAX_HOLD and (req & ~(1<<o))!=0.
  - On release:
    - ptr <= o+1 (mod 4).
    - Search req & ~(1<<o) starting at o+1.
    - If any bit is set, grant the winner at the same edge with hold_cnt=1. Back-to-back with no idle cycle; gnt is never zero between owners.
    - Otherwise gnt=0 and go to IDLE.
  - No release: keep the grant; hold_cnt increments, saturating at MAX_HOLD.
  - Owner alone at MAX_HOLD: keeps the grant indefinitely. If another request arrives later, release occurs at the next edge.
- Simultaneous events:
  - Owner drops req in the same edge that hold expires: treated as a single release, same result.
  - New requests arriving at the release edge participate in the search.
  - Owner re-raising req at the release edge is excluded from the search. It is served later in rotation.
- Invariants:
  - gnt is always zero or one-hot.
  - gnt[i] implies req[i] was high at the edge that granted it.
  - A requester that is continuously waiting is granted within 3*MAX_HOLD+3 cycles.
- Requester protocol:
  - The requester keeps A slice stable while granted.
  - Dropping req ends ownership at the next edge. out still shows that requester's data for the cycle before that edge.

Test Plan:
- Reset then req=4'b0100, A slices {3:0xD3,2:0xC2,1:0xB1,0:0xA0} -> one cycle later gnt=0100, sel=2, out=0xC2, out_vld=1. req=0 -> next cycle gnt=0, out=0x00.
- req=4'b1111 held, MAX_HOLD=4 -> grants rotate 0,1,2,3,0. Each grant lasts exactly 4 cycles; no idle cycle between grants.
- req=4'b0010 held alone for 20 cycles -> gnt=0010 throughout. Raise req[3] at cycle 20 -> gnt=1000 on the next edge, ptr=2.
- Owner 0 drops req after 2 cycles while req[2]=1 -> gnt switches 0001->0100 at that edge. hold_cnt restarts, so owner 2 holds for 4 cycles.
- Assert rst_n=0 mid-grant (gnt=1000) -> gnt=0, out=0 immediately. After release with req=1111, the first grant is 0001.
- Owner 1 expires with req=0011 -> gnt=0001. Owner 0 then expires with req=0011 -> gnt=0010; owner 1 is not starved.
